// File: rtl/zap_regf_wr_queue.sv
`default_nettype none
// ============================================================================
// zap_regf_wr_queue: in-order write-back queue feeding a dual-write-port
// register file, with youngest-match forwarding to four operand read ports.
// Revision: 1.0
// ============================================================================
module zap_regf_wr_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 6,
   parameter int NREGS = 40
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_valid_a,
   input  logic [AW-1:0] i_addr_a,
   input  logic [DW-1:0] i_data_a,
   input  logic          i_valid_b,
   input  logic [AW-1:0] i_addr_b,
   input  logic [DW-1:0] i_data_b,
   output logic          o_ready,
   output logic          o_err,
   output logic          o_wen,
   output logic [AW-1:0] o_wr_addr_a,
   output logic [AW-1:0] o_wr_addr_b,
   output logic [DW-1:0] o_wr_data_a,
   output logic [DW-1:0] o_wr_data_b,
   input  logic [AW-1:0] i_rd_addr_a,
   input  logic [AW-1:0] i_rd_addr_b,
   input  logic [AW-1:0] i_rd_addr_c,
   input  logic [AW-1:0] i_rd_addr_d,
   output logic [3:0]    o_fwd_hit,
   output logic [DW-1:0] o_fwd_data_a,
   output logic [DW-1:0] o_fwd_data_b,
   output logic [DW-1:0] o_fwd_data_c,
   output logic [DW-1:0] o_fwd_data_d,
   output logic          o_idle
);

   localparam int              c_pw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_cw     = c_pw + 1;
   localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
   localparam logic [AW:0]     c_nregs  = (AW+1)'(NREGS);

   logic [AW-1:0]   ent_addr_q [DEPTH];
   logic [AW-1:0]   ent_addr_d [DEPTH];
   logic [DW-1:0]   ent_data_q [DEPTH];
   logic [DW-1:0]   ent_data_d [DEPTH];
   logic [c_pw-1:0] head_q, head_d;
   logic [c_pw-1:0] tail_q, tail_d;
   logic [c_cw-1:0] count_q, count_d;
   logic            wen_q, wen_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_addr_a_q, wr_addr_a_d;
   logic [AW-1:0]   wr_addr_b_q, wr_addr_b_d;
   logic [DW-1:0]   wr_data_a_q, wr_data_a_d;
   logic [DW-1:0]   wr_data_b_q, wr_data_b_d;

   logic            w_ready;
   logic            w_legal_a, w_legal_b;
   logic            w_push_a, w_push_b;
   logic [c_pw-1:0] w_head_p1;
   logic [c_pw-1:0] w_wp;
   logic [c_cw-1:0] w_n_push, w_n_pop;
   logic [c_pw-1:0] w_idx;
   logic [AW-1:0]   w_rd_addr  [4];
   logic [DW-1:0]   w_fwd_data [4];
   logic [3:0]      w_hit;

   assign w_ready   = (c_depth - count_q) >= c_cw'(2);
   assign w_legal_a = {1'b0, i_addr_a} < c_nregs;
   assign w_legal_b = {1'b0, i_addr_b} < c_nregs;
   assign w_push_a  = w_ready && i_valid_a && w_legal_a;
   assign w_push_b  = w_ready && i_valid_b && w_legal_b;
   assign w_head_p1 = head_q + c_pw'(1);

   always_comb begin
      ent_addr_d  = ent_addr_q;
      ent_data_d  = ent_data_q;
      head_d      = head_q;
      wen_d       = 1'b0;
      wr_addr_a_d = wr_addr_a_q;
      wr_addr_b_d = wr_addr_b_q;
      wr_data_a_d = wr_data_a_q;
      wr_data_b_d = wr_data_b_q;
      w_n_pop     = '0;
      w_n_push    = '0;
      w_wp        = tail_q;
      err_d       = (w_ready && i_valid_a && !w_legal_a) ||
                    (w_ready && i_valid_b && !w_legal_b);

      // Drain decision uses the pre-enqueue count; an idle output stage
      // keeps its address/data because the bank select follows every edge.
      if (count_q >= c_cw'(2)) begin
         wr_addr_a_d = ent_addr_q[head_q];
         wr_data_a_d = ent_data_q[head_q];
         wr_addr_b_d = ent_addr_q[w_head_p1];
         wr_data_b_d = ent_data_q[w_head_p1];
         wen_d       = 1'b1;
         w_n_pop     = c_cw'(2);
         head_d      = head_q + c_pw'(2);
      end else if (count_q == c_cw'(1)) begin
         wr_addr_a_d = ent_addr_q[head_q];
         wr_data_a_d = ent_data_q[head_q];
         wr_addr_b_d = ent_addr_q[head_q];
         wr_data_b_d = ent_data_q[head_q];
         wen_d       = 1'b1;
         w_n_pop     = c_cw'(1);
         head_d      = w_head_p1;
      end

      if (w_push_a) begin
         ent_addr_d[w_wp] = i_addr_a;
         ent_data_d[w_wp] = i_data_a;
         w_wp             = w_wp + c_pw'(1);
         w_n_push         = w_n_push + c_cw'(1);
      end
      if (w_push_b) begin
         ent_addr_d[w_wp] = i_addr_b;
         ent_data_d[w_wp] = i_data_b;
         w_wp             = w_wp + c_pw'(1);
         w_n_push         = w_n_push + c_cw'(1);
      end
      tail_d  = w_wp;
      count_d = count_q + w_n_push - w_n_pop;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         wen_q       <= 1'b0;
         err_q       <= 1'b0;
         wr_addr_a_q <= '0;
         wr_addr_b_q <= '0;
         wr_data_a_q <= '0;
         wr_data_b_q <= '0;
      end else begin
         ent_addr_q  <= ent_addr_d;
         ent_data_q  <= ent_data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         wen_q       <= wen_d;
         err_q       <= err_d;
         wr_addr_a_q <= wr_addr_a_d;
         wr_addr_b_q <= wr_addr_b_d;
         wr_data_a_q <= wr_data_a_d;
         wr_data_b_q <= wr_data_b_d;
      end
   end

   assign w_rd_addr[0] = i_rd_addr_a;
   assign w_rd_addr[1] = i_rd_addr_b;
   assign w_rd_addr[2] = i_rd_addr_c;
   assign w_rd_addr[3] = i_rd_addr_d;

   // Scan oldest to youngest so the last match (youngest) wins: output
   // port A, output port B, then FIFO head towards tail.
   always_comb begin
      w_hit = '0;
      w_idx = head_q;
      for (int k = 0; k < 4; k++) begin
         w_fwd_data[k] = '0;
         if (wen_q && (wr_addr_a_q == w_rd_addr[k])) begin
            w_hit[k]      = 1'b1;
            w_fwd_data[k] = wr_data_a_q;
         end
         if (wen_q && (wr_addr_b_q == w_rd_addr[k])) begin
            w_hit[k]      = 1'b1;
            w_fwd_data[k] = wr_data_b_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + c_pw'(i);
            if ((c_cw'(i) < count_q) && (ent_addr_q[w_idx] == w_rd_addr[k])) begin
               w_hit[k]      = 1'b1;
               w_fwd_data[k] = ent_data_q[w_idx];
            end
         end
      end
   end

   assign o_ready      = w_ready;
   assign o_err        = err_q;
   assign o_wen        = wen_q;
   assign o_wr_addr_a  = wr_addr_a_q;
   assign o_wr_addr_b  = wr_addr_b_q;
   assign o_wr_data_a  = wr_data_a_q;
   assign o_wr_data_b  = wr_data_b_q;
   assign o_fwd_hit    = w_hit;
   assign o_fwd_data_a = w_fwd_data[0];
   assign o_fwd_data_b = w_fwd_data[1];
   assign o_fwd_data_c = w_fwd_data[2];
   assign o_fwd_data_d = w_fwd_data[3];
   assign o_idle       = (count_q == '0) && !wen_q;

endmodule
`default_nettype wire
